// File: rtl/w0rm_seq_int_div_if.sv
// Operand/result handshake bundle shared by the divider core and its consumer.
interface w0rm_seq_int_div_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  data_valid;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  result_valid;
  logic                  div_by_zero;
  logic                  overflow;

  // Requester side: presents operands, observes results.
  modport master (
    output data_valid, dividend, divisor,
    input  ready, quotient, remainder, result_valid, div_by_zero, overflow
  );

  // Divider side: consumes operands, produces registered results.
  modport slave (
    input  data_valid, dividend, divisor,
    output ready, quotient, remainder, result_valid, div_by_zero, overflow
  );

endinterface

// File: rtl/w0rm_seq_int_div.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle, MSB first,
// quotient and remainder delivered together with a one-cycle result_valid.
module w0rm_seq_int_div #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIGNED     = 0
) (
  input  logic              clk,
  input  logic              reset,
  w0rm_seq_int_div_if.slave bus
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(W);
  localparam bit          IS_SIGNED = (SIGNED != 0);

  localparam logic [W-1:0] MIN_INT  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_d;

  // Operand capture and iteration state.
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     shq_q;      // dividend bits shift out, quotient bits shift in
  logic [W-1:0]     dvs_q;      // divisor magnitude
  logic [W-1:0]     raw_q;      // dividend as presented, for divide-by-zero
  logic [W-1:0]     rem_q;      // partial remainder (always < divisor)
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dbz_q;
  logic             ovf_q;

  // Registered outputs.
  logic             ready_q;
  logic             rv_q;
  logic [W-1:0]     quo_out_q;
  logic [W-1:0]     rem_out_q;
  logic             dbz_out_q;
  logic             ovf_out_q;

  logic             accept_c;
  logic             dvd_neg_c;
  logic             dvs_neg_c;
  logic [W-1:0]     dvd_abs_c;
  logic [W-1:0]     dvs_abs_c;
  logic [W:0]       rem_sh_c;
  logic [W:0]       diff_c;
  logic             qbit_c;
  logic [W-1:0]     fix_quo_c;
  logic [W-1:0]     fix_rem_c;

  // Operand strobe is taken only while the core advertises ready.
  assign accept_c  = ready_q & bus.data_valid;

  // Magnitudes for signed mode; |MIN_INT| wraps to 2^(W-1) as an unsigned value.
  assign dvd_neg_c = IS_SIGNED & bus.dividend[W-1];
  assign dvs_neg_c = IS_SIGNED & bus.divisor[W-1];
  assign dvd_abs_c = dvd_neg_c ? (W'(0) - bus.dividend) : bus.dividend;
  assign dvs_abs_c = dvs_neg_c ? (W'(0) - bus.divisor)  : bus.divisor;

  // One restoring step: shift in next dividend bit, trial-subtract the divisor.
  assign rem_sh_c  = {rem_q, shq_q[W-1]};
  assign diff_c    = rem_sh_c - {1'b0, dvs_q};
  assign qbit_c    = ~diff_c[W];

  // Sign correction and special-case overrides applied in FIX.
  always_comb begin
    fix_quo_c = neg_quo_q ? (W'(0) - shq_q) : shq_q;
    fix_rem_c = neg_rem_q ? (W'(0) - rem_q) : rem_q;
    if (dbz_q) begin
      fix_quo_c = ALL_ONES;
      fix_rem_c = raw_q;
    end else if (ovf_q) begin
      fix_quo_c = MIN_INT;
      fix_rem_c = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the accept cycle is spent in IDLE with pend_q set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pend_q)       state_d = S_CALC;
      S_CALC: if (cnt_q == '0)  state_d = S_FIX;
      S_FIX:                    state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, then one quotient bit per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      shq_q     <= '0;
      dvs_q     <= '0;
      raw_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pend_q <= accept_c;
      if (accept_c) begin
        cnt_q     <= CNT_W'(W - 1);
        shq_q     <= dvd_abs_c;
        dvs_q     <= dvs_abs_c;
        raw_q     <= bus.dividend;
        rem_q     <= '0;
        neg_quo_q <= dvd_neg_c ^ dvs_neg_c;
        neg_rem_q <= dvd_neg_c;
        dbz_q     <= (bus.divisor == '0);
        ovf_q     <= IS_SIGNED & (bus.dividend == MIN_INT) & (bus.divisor == ALL_ONES);
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q - CNT_W'(1);
        shq_q <= {shq_q[W-2:0], qbit_c};
        rem_q <= qbit_c ? diff_c[W-1:0] : rem_sh_c[W-1:0];
      end
    end
  end

  // Registered outputs; results and flags move only on the FIX->DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b1;
      rv_q      <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      ready_q <= (state_d == S_IDLE) & ~accept_c;
      rv_q    <= (state_q == S_FIX);
      if (state_q == S_FIX) begin
        quo_out_q <= fix_quo_c;
        rem_out_q <= fix_rem_c;
        dbz_out_q <= dbz_q;
        ovf_out_q <= ovf_q & ~dbz_q;
      end
    end
  end

  assign bus.ready        = ready_q;
  assign bus.result_valid = rv_q;
  assign bus.quotient     = quo_out_q;
  assign bus.remainder    = rem_out_q;
  assign bus.div_by_zero  = dbz_out_q;
  assign bus.overflow     = ovf_out_q;

endmodule
